// File: rtl/divisor_seq_ctrl_if.sv
// Front-panel / divider bundle for divisor_seq_ctrl.
// master = controller side, slave = panel buttons plus divider datapath.
interface divisor_seq_ctrl_if #(
    parameter int W = 4
);
    logic         up;
    logic         down;
    logic         ok;
    logic         div_done;
    logic [W-1:0] div_q;
    logic [W-1:0] div_r;
    logic         div_start;
    logic [W-1:0] num;
    logic [W-1:0] den;
    logic [W-1:0] leds;
    logic [1:0]   sel;
    logic         busy;
    logic         err;

    modport master (
        input  up, down, ok,
        input  div_done, div_q, div_r,
        output div_start, num, den,
        output leds, sel, busy, err
    );

    modport slave (
        output up, down, ok,
        output div_done, div_q, div_r,
        input  div_start, num, den,
        input  leds, sel, busy, err
    );
endinterface

// File: rtl/divisor_seq_ctrl.sv
// Front-panel sequencer for a W-bit divider: operand entry, start/done, result display.
// Optional DIV_TIMEOUT_EN aborts a wait longer than TIMEOUT cycles into S_ERR.
module divisor_seq_ctrl #(
    parameter int W = 4
`ifdef DIV_TIMEOUT_EN
    , parameter int TIMEOUT = 32
`endif
) (
    input logic                clk,
    input logic                rst,
    divisor_seq_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_NUM, S_DEN, S_START, S_WAIT, S_QUO, S_REM, S_ERR
    } state_e;

    state_e       state_q, state_d;
    logic [2:0]   prev_q;
    logic [W-1:0] num_q, num_d;
    logic [W-1:0] den_q, den_d;
    logic [W-1:0] q_q, q_d;
    logic [W-1:0] r_q, r_d;
    logic         up_e, dn_e, ok_e;
    logic         start_o, busy_o, err_o;
    logic [W-1:0] leds_o;
    logic [1:0]   sel_o;

    assign up_e = bus.up   & ~prev_q[0];
    assign dn_e = bus.down & ~prev_q[1];
    assign ok_e = bus.ok   & ~prev_q[2];

`ifdef DIV_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;
    logic          tmo;

    always_ff @(posedge clk) begin
        if (rst || state_q != S_WAIT) cnt_q <= '0;
        else                          cnt_q <= cnt_q + CW'(1);
    end

    assign tmo = (cnt_q == CW'(TIMEOUT - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_NUM;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_NUM:   if (ok_e) state_d = S_DEN;
            S_DEN:   if (ok_e) state_d = (den_q != '0) ? S_START : S_ERR;
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.div_done) state_d = S_QUO;
`ifdef DIV_TIMEOUT_EN
                else if (tmo)     state_d = S_ERR;
`endif
            end
            S_QUO:   if (ok_e) state_d = S_REM;
            S_REM:   if (ok_e) state_d = S_NUM;
            S_ERR:   if (ok_e) state_d = S_DEN;
            default: state_d = S_NUM;
        endcase
    end

    // ok wins over up/down; simultaneous up and down cancel
    always_comb begin
        num_d = num_q;
        den_d = den_q;
        q_d   = q_q;
        r_d   = r_q;
        if (!ok_e && (up_e ^ dn_e)) begin
            if (state_q == S_NUM)
                num_d = up_e ? num_q + W'(1) : num_q - W'(1);
            if (state_q == S_DEN)
                den_d = up_e ? den_q + W'(1) : den_q - W'(1);
        end
        if (state_q == S_WAIT && bus.div_done) begin
            q_d = bus.div_q;
            r_d = bus.div_r;
        end
    end

    // history starts at 1 so a button held through reset gives no edge
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '1;
            num_q  <= '0;
            den_q  <= '0;
            q_q    <= '0;
            r_q    <= '0;
        end else begin
            prev_q <= {bus.ok, bus.down, bus.up};
            num_q  <= num_d;
            den_q  <= den_d;
            q_q    <= q_d;
            r_q    <= r_d;
        end
    end

    always_comb begin
        start_o = 1'b0;
        busy_o  = 1'b0;
        err_o   = 1'b0;
        leds_o  = '0;
        sel_o   = 2'b01;
        unique case (state_q)
            S_NUM: begin
                leds_o = num_q;
                sel_o  = 2'b00;
            end
            S_DEN:   leds_o = den_q;
            S_START: begin
                start_o = 1'b1;
                busy_o  = 1'b1;
            end
            S_WAIT:  busy_o = 1'b1;
            S_QUO: begin
                leds_o = q_q;
                sel_o  = 2'b10;
            end
            S_REM: begin
                leds_o = r_q;
                sel_o  = 2'b11;
            end
            S_ERR: begin
                leds_o = '1;
                err_o  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.div_start = start_o;
    assign bus.busy      = busy_o;
    assign bus.err       = err_o;
    assign bus.leds      = leds_o;
    assign bus.sel       = sel_o;
    assign bus.num       = num_q;
    assign bus.den       = den_q;

endmodule
